// File: rtl/traffic_pkg.sv
// Shared types and helpers for the multi-phase traffic controller.
// Holds the FSM state encoding and the phase-index width function.
package traffic_pkg;

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2,
        S_FLASH  = 2'd3
    } state_t;

    // Phase index width: max(1, clog2(n)).
    function automatic int ph_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Bundle of controller requests and lamp outputs.
// master: request side (tick, flash_en, ped_req); slave: the controller.
interface traffic_phase_ctrl_if
    import traffic_pkg::*;
#(
    parameter int NUM_PH = 2
);
    localparam int PH_W = ph_width(NUM_PH);

    logic              tick;
    logic              flash_en;
    logic [NUM_PH-1:0] ped_req;
    logic [NUM_PH-1:0] green;
    logic [NUM_PH-1:0] yellow;
    logic [NUM_PH-1:0] red;
    logic [NUM_PH-1:0] walk;
    logic [NUM_PH-1:0] ped_pend;
    logic [PH_W-1:0]   phase;
    logic              flashing;

    modport master (
        output tick, flash_en, ped_req,
        input  green, yellow, red, walk, ped_pend, phase, flashing
    );

    modport slave (
        input  tick, flash_en, ped_req,
        output green, yellow, red, walk, ped_pend, phase, flashing
    );

endinterface

// File: rtl/tl_tick_timer.sv
// Tick-driven duration counter; done pulses on the last tick of dur.
// Ports: clk, rst, tick, clr (force to 0), dur, done (auto-clears cnt).
module tl_tick_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    input  logic [CNT_W-1:0] dur,
    output logic             done
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        done  = tick && (cnt_q == (dur - CNT_W'(1)));
        cnt_d = cnt_q;
        if (clr || done) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin multi-phase signal controller with walk and night flash.
// Ports: clk, rst, bus (slave: tick/flash_en/ped_req in, lamps out).
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_PH = 2,
    parameter int G_T    = 5,
    parameter int Y_T    = 2,
    parameter int AR_T   = 1,
    parameter int WALK_T = 3,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_phase_ctrl_if.slave  bus
);
    localparam int PH_W = ph_width(NUM_PH);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [NUM_PH-1:0] ped_pend_q, ped_pend_d;
    logic              walk_act_q, walk_act_d;
    logic              blink_q, blink_d;

    logic              clr;
    logic              done;
    logic [CNT_W-1:0]  dur;
    logic [PH_W-1:0]   ph_nx;

    tl_tick_timer #(.CNT_W(CNT_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (bus.tick),
        .clr  (clr),
        .dur  (dur),
        .done (done)
    );

    always_comb begin
        ph_nx = (phase_q == PH_W'(NUM_PH - 1)) ? '0 : phase_q + PH_W'(1);
        unique case (state_q)
            S_GREEN:  dur = CNT_W'(G_T) + (walk_act_q ? CNT_W'(WALK_T) : '0);
            S_YELLOW: dur = CNT_W'(Y_T);
            S_ALLRED: dur = CNT_W'(AR_T);
            default:  dur = CNT_W'(1);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        walk_act_d = walk_act_q;
        blink_d    = blink_q;
        // Requests latch in every state; green entry clears its own bit.
        ped_pend_d = ped_pend_q | bus.ped_req;
        clr        = 1'b0;
        if (int'(phase_q) >= NUM_PH) begin
            state_d    = S_GREEN;
            phase_d    = '0;
            walk_act_d = 1'b0;
            blink_d    = 1'b0;
            clr        = 1'b1;
        end else begin
            case (state_q)
                S_GREEN: begin
                    if (done) state_d = S_YELLOW;
                end
                S_YELLOW: begin
                    if (done) state_d = S_ALLRED;
                end
                S_ALLRED: begin
                    if (done) begin
                        if (bus.flash_en) begin
                            state_d = S_FLASH;
                            blink_d = 1'b0;
                        end else begin
                            state_d    = S_GREEN;
                            phase_d    = ph_nx;
                            walk_act_d = ped_pend_q[ph_nx] | bus.ped_req[ph_nx];
                            ped_pend_d[ph_nx] = 1'b0;
                        end
                    end
                end
                S_FLASH: begin
                    clr = 1'b1;
                    if (bus.tick) begin
                        blink_d = ~blink_q;
                        // Exit via all-red on the last phase so phase 0 leads.
                        if (!bus.flash_en) begin
                            state_d = S_ALLRED;
                            phase_d = PH_W'(NUM_PH - 1);
                            blink_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = S_GREEN;
                    phase_d = '0;
                    clr     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_GREEN;
            phase_q    <= '0;
            ped_pend_q <= '0;
            walk_act_q <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            ped_pend_q <= ped_pend_d;
            walk_act_q <= walk_act_d;
            blink_q    <= blink_d;
        end
    end

    always_comb begin
        bus.green  = '0;
        bus.yellow = '0;
        bus.red    = '1;
        bus.walk   = '0;
        case (state_q)
            S_GREEN: begin
                bus.green[phase_q] = 1'b1;
                bus.red[phase_q]   = 1'b0;
                bus.walk[phase_q]  = walk_act_q;
            end
            S_YELLOW: begin
                bus.yellow[phase_q] = 1'b1;
                bus.red[phase_q]    = 1'b0;
            end
            S_FLASH: begin
                bus.red       = {NUM_PH{blink_q}};
                bus.red[0]    = 1'b0;
                bus.yellow[0] = blink_q;
            end
            default: ;
        endcase
    end

    assign bus.ped_pend = ped_pend_q;
    assign bus.phase    = phase_q;
    assign bus.flashing = (state_q == S_FLASH);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl, NUM_PH=3, G_T=5, Y_T=2, AR_T=1.
// Cycle k is the interval after edge k-1; inputs are sampled at edge k.
module tb_traffic_phase_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    traffic_phase_ctrl_if #(.NUM_PH(3)) bus ();

    traffic_phase_ctrl #(
        .NUM_PH(3), .G_T(5), .Y_T(2), .AR_T(1), .WALK_T(3), .CNT_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.ped_req = '0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.tick     = 1'b0;
        bus.flash_en = 1'b0;
        bus.ped_req  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Lamps packed {green, yellow, red} for the plain 8-cycle rotation.
    function automatic logic [8:0] lamps(input int c);
        int p;
        int w;
        logic [2:0] one;
        p   = (c / 8) % 3;
        w   = c % 8;
        one = 3'b001 << p;
        if (w < 5)      return {one, 3'b000, ~one};
        else if (w < 7) return {3'b000, one, ~one};
        else            return {3'b000, 3'b000, 3'b111};
    endfunction

    initial begin
        bus.tick     = 1'b0;
        bus.flash_en = 1'b0;
        bus.ped_req  = '0;

        // Reset state
        do_reset();
        check("rst_green", 32'(bus.green), 32'h1);
        check("rst_red", 32'(bus.red), 32'h6);
        check("rst_yellow", 32'(bus.yellow), 32'h0);
        check("rst_walk", 32'(bus.walk), 32'h0);
        check("rst_flash", 32'(bus.flashing), 32'h0);
        check("rst_phase", 32'(bus.phase), 32'h0);
        check("rst_pend", 32'(bus.ped_pend), 32'h0);

        // Timing sequence, tick every cycle
        bus.tick = 1'b1;
        for (int c = 0; c <= 24; c++) begin
            check($sformatf("seq_c%0d", c),
                  32'({bus.green, bus.yellow, bus.red}), 32'(lamps(c)));
            step();
        end

        // Walk extension on phase 1
        do_reset();
        bus.tick = 1'b1;
        for (int c = 0; c <= 17; c++) begin
            if (c == 2) bus.ped_req = 3'b010;
            if (c >= 1)
                check($sformatf("wpend_c%0d", c), 32'(bus.ped_pend[1]),
                      32'(c >= 3 && c <= 7));
            if (c >= 6) begin
                check($sformatf("wgrn_c%0d", c), 32'(bus.green[1]),
                      32'(c >= 8 && c <= 15));
                check($sformatf("wwalk_c%0d", c), 32'(bus.walk[1]),
                      32'(c >= 8 && c <= 15));
                check($sformatf("wyel_c%0d", c), 32'(bus.yellow[1]),
                      32'(c >= 16));
            end
            step();
        end

        // Request on the active phase is held for its next green
        do_reset();
        bus.tick = 1'b1;
        for (int c = 0; c <= 32; c++) begin
            if (c == 1) bus.ped_req = 3'b001;
            if (c <= 4) begin
                check($sformatf("agrn_c%0d", c), 32'(bus.green[0]), 32'h1);
                check($sformatf("awalk_c%0d", c), 32'(bus.walk[0]), 32'h0);
            end
            if (c == 3 || c == 20)
                check($sformatf("apend_c%0d", c), 32'(bus.ped_pend[0]), 32'h1);
            if (c >= 24 && c <= 31) begin
                check($sformatf("agrn_c%0d", c), 32'(bus.green[0]), 32'h1);
                check($sformatf("awalk_c%0d", c), 32'(bus.walk[0]), 32'h1);
                check($sformatf("apend_c%0d", c), 32'(bus.ped_pend[0]), 32'h0);
            end
            if (c == 32)
                check("ayel_c32", 32'(bus.yellow[0]), 32'h1);
            step();
        end

        // Flash entry and exit
        do_reset();
        bus.tick = 1'b1;
        for (int c = 0; c <= 15; c++) begin
            if (c == 3) bus.flash_en = 1'b1;
            if (c == 13) bus.flash_en = 1'b0;
            if (c <= 7)
                check($sformatf("f_c%0d", c),
                      32'({bus.green, bus.yellow, bus.red}), 32'(lamps(c)));
            if (c >= 8 && c <= 13) begin
                check($sformatf("fon_c%0d", c), 32'(bus.flashing), 32'h1);
                check($sformatf("fyel_c%0d", c), 32'(bus.yellow),
                      32'((c - 8) % 2));
                check($sformatf("fred_c%0d", c), 32'(bus.red),
                      ((c - 8) % 2) ? 32'h6 : 32'h0);
                check($sformatf("fgrn_c%0d", c), 32'(bus.green), 32'h0);
            end
            if (c == 14) begin
                check("fx_flash", 32'(bus.flashing), 32'h0);
                check("fx_red", 32'(bus.red), 32'h7);
                check("fx_phase", 32'(bus.phase), 32'h2);
            end
            if (c == 15) begin
                check("fx_green", 32'(bus.green), 32'h1);
                check("fx_phase0", 32'(bus.phase), 32'h0);
            end
            step();
        end

        // Sparse ticks, every 4th cycle
        do_reset();
        for (int c = 0; c <= 29; c++) begin
            bus.tick = (c % 4 == 0);
            if (c <= 16)
                check($sformatf("sg_c%0d", c), 32'(bus.green), 32'h1);
            else if (c <= 24)
                check($sformatf("sy_c%0d", c), 32'(bus.yellow), 32'h1);
            else if (c <= 28)
                check($sformatf("sr_c%0d", c), 32'(bus.red), 32'h7);
            else
                check("sg1_c29", 32'(bus.green), 32'h2);
            step();
        end

        // Reset mid-yellow with a pending request
        do_reset();
        bus.tick = 1'b1;
        for (int c = 0; c <= 13; c++) begin
            if (c == 2) bus.ped_req = 3'b100;
            step();
        end
        check("ry_yel", 32'(bus.yellow), 32'h2);
        check("ry_pend", 32'(bus.ped_pend), 32'h4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("ry_green", 32'(bus.green), 32'h1);
        check("ry_phase", 32'(bus.phase), 32'h0);
        check("ry_pend0", 32'(bus.ped_pend), 32'h0);
        check("ry_walk", 32'(bus.walk), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
